// File: rtl/fp_issue_wb_if.sv
// Bundle between the FP register-read stage, the fp_add_sub / fp_mul units and the
// FP register-file write port. The sequencer is the slave side; its environment is the master.
interface fp_issue_wb_if #(
  parameter int RV  = 64,
  parameter int TAG = 6
);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_op;
  logic           in_sz;
  logic [2:0]     in_rnd;
  logic [2:0]     frm;
  logic [RV-1:0]  in_a;
  logic [RV-1:0]  in_b;
  logic [TAG-1:0] in_tag;

  logic           add_sub;
  logic           add_sz;
  logic [2:0]     add_rnd;
  logic [RV-1:0]  add_in_1;
  logic [RV-1:0]  add_in_2;
  logic           mul_sz;
  logic [2:0]     mul_rnd;
  logic [RV-1:0]  mul_in_1;
  logic [RV-1:0]  mul_in_2;

  logic [RV-1:0]  add_res;
  logic           add_exception;
  logic [RV-1:0]  mul_res;
  logic           mul_exception;

  logic           wb_valid;
  logic           wb_ready;
  logic [TAG-1:0] wb_tag;
  logic [RV-1:0]  wb_res;
  logic           wb_exc;

  // Both handshakes: a transfer happens on a clock edge where valid and ready are
  // both 1; ready never looks at valid, and valid is held by the sender until it transfers.
  modport slave (
    input  in_valid, in_op, in_sz, in_rnd, frm, in_a, in_b, in_tag,
    input  add_res, add_exception, mul_res, mul_exception, wb_ready,
    output in_ready, add_sub, add_sz, add_rnd, add_in_1, add_in_2,
    output mul_sz, mul_rnd, mul_in_1, mul_in_2,
    output wb_valid, wb_tag, wb_res, wb_exc
  );

  modport master (
    output in_valid, in_op, in_sz, in_rnd, frm, in_a, in_b, in_tag,
    output add_res, add_exception, mul_res, mul_exception, wb_ready,
    input  in_ready, add_sub, add_sz, add_rnd, add_in_1, add_in_2,
    input  mul_sz, mul_rnd, mul_in_1, mul_in_2,
    input  wb_valid, wb_tag, wb_res, wb_exc
  );
endinterface

// File: rtl/fp_issue_wb.sv
// FP add/sub/mul issue and write-back sequencer: NaN-boxing, rounding resolution,
// launch registers for the two units, tag tracking and a credit-protected result FIFO.
module fp_issue_wb #(
  parameter int RV    = 64,
  parameter int TAG   = 6,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  fp_issue_wb_if.slave  bus
);
  localparam int          CW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = DEPTH;

  function automatic logic [RV-1:0] nan_box(input logic [RV-1:0] v, input logic sz);
    if (sz || (&v[RV-1:32])) return v;
    return {{(RV-32){1'b1}}, 32'h7fc0_0000};
  endfunction

  logic           run_q, mul_last_q;
  logic           a_v_q, a_ill_q, m1_v_q, m2_v_q;
  logic [TAG-1:0] a_tag_q, m1_tag_q, m2_tag_q;
  logic           add_sub_q, add_sz_q, mul_sz_q;
  logic [2:0]     add_rnd_q, mul_rnd_q;
  logic [RV-1:0]  add_in_1_q, add_in_2_q, mul_in_1_q, mul_in_2_q;
  logic [TAG-1:0] tag_mem_q [DEPTH];
  logic [RV-1:0]  res_mem_q [DEPTH];
  logic           exc_mem_q [DEPTH];
  logic [CW-1:0]  wptr_q, rptr_q;
  logic [CW:0]    count_q;

  logic [2:0]     eff_rm;
  logic           illegal, to_mul, accept, ready, pop;
  logic [31:0]    used;
  logic           push_d, push_exc_d;
  logic [TAG-1:0] push_tag_d;
  logic [RV-1:0]  push_res_d;

  always_comb begin
    eff_rm  = (bus.in_rnd == 3'b111) ? bus.frm : bus.in_rnd;
    illegal = (bus.in_op == 2'b11) || (eff_rm inside {3'b101, 3'b110, 3'b111});
    to_mul  = (bus.in_op == 2'b10) && !illegal;
    used    = 32'(count_q) + 32'(a_v_q) + 32'(m1_v_q) + 32'(m2_v_q);
    // An illegal mul completes on the add path, so it is held off after a mul as well.
    ready   = run_q && (used < DEPTH_U) && !(mul_last_q && !to_mul);
    accept  = bus.in_valid && ready;
    pop     = (count_q != '0) && bus.wb_ready;
  end

  always_comb begin
    push_d     = a_v_q || m2_v_q;
    push_tag_d = a_tag_q;
    push_res_d = bus.add_res;
    push_exc_d = bus.add_exception;
    if (m2_v_q) begin
      push_tag_d = m2_tag_q;
      push_res_d = bus.mul_res;
      push_exc_d = bus.mul_exception;
    end else if (a_ill_q) begin
      push_res_d = '0;
      push_exc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      mul_last_q <= 1'b0;
      a_v_q      <= 1'b0;
      a_ill_q    <= 1'b0;
      a_tag_q    <= '0;
      m1_v_q     <= 1'b0;
      m1_tag_q   <= '0;
      m2_v_q     <= 1'b0;
      m2_tag_q   <= '0;
      add_sub_q  <= 1'b0;
      add_sz_q   <= 1'b0;
      add_rnd_q  <= '0;
      add_in_1_q <= '0;
      add_in_2_q <= '0;
      mul_sz_q   <= 1'b0;
      mul_rnd_q  <= '0;
      mul_in_1_q <= '0;
      mul_in_2_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i] <= '0;
        res_mem_q[i] <= '0;
        exc_mem_q[i] <= 1'b0;
      end
    end else begin
      // Keeps in_ready low for the first cycle after reset release.
      run_q      <= 1'b1;
      mul_last_q <= accept && to_mul;
      a_v_q      <= accept && !to_mul;
      a_ill_q    <= illegal;
      a_tag_q    <= bus.in_tag;
      m1_v_q     <= accept && to_mul;
      m1_tag_q   <= bus.in_tag;
      m2_v_q     <= m1_v_q;
      m2_tag_q   <= m1_tag_q;
      if (accept && !to_mul && !illegal) begin
        add_sub_q  <= (bus.in_op == 2'b01);
        add_sz_q   <= bus.in_sz;
        add_rnd_q  <= eff_rm;
        add_in_1_q <= nan_box(bus.in_a, bus.in_sz);
        add_in_2_q <= nan_box(bus.in_b, bus.in_sz);
      end
      if (accept && to_mul) begin
        mul_sz_q   <= bus.in_sz;
        mul_rnd_q  <= eff_rm;
        mul_in_1_q <= nan_box(bus.in_a, bus.in_sz);
        mul_in_2_q <= nan_box(bus.in_b, bus.in_sz);
      end
      if (push_d) begin
        tag_mem_q[wptr_q] <= push_tag_d;
        res_mem_q[wptr_q] <= push_res_d;
        exc_mem_q[wptr_q] <= push_exc_d;
        wptr_q            <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push_d && !pop)      count_q <= count_q + 1'b1;
      else if (!push_d && pop) count_q <= count_q - 1'b1;
    end
  end

  assign bus.in_ready = ready;
  assign bus.add_sub  = add_sub_q;
  assign bus.add_sz   = add_sz_q;
  assign bus.add_rnd  = add_rnd_q;
  assign bus.add_in_1 = add_in_1_q;
  assign bus.add_in_2 = add_in_2_q;
  assign bus.mul_sz   = mul_sz_q;
  assign bus.mul_rnd  = mul_rnd_q;
  assign bus.mul_in_1 = mul_in_1_q;
  assign bus.mul_in_2 = mul_in_2_q;
  assign bus.wb_valid = (count_q != '0);
  assign bus.wb_tag   = tag_mem_q[rptr_q];
  assign bus.wb_res   = res_mem_q[rptr_q];
  assign bus.wb_exc   = exc_mem_q[rptr_q];
endmodule
